// File: rtl/ball_split_scheduler_if.sv
// Hit / spawn bus between the collision logic, the ball split scheduler
// and the per-slot ball movement/bitmap instances.
interface ball_split_scheduler_if #(
    parameter int NUM_SLOTS = 8,
    parameter int LEVEL_W   = 2
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                         startLevel;
    logic [LEVEL_W-1:0]           initLevel;
    logic                         hitValid;
    logic [SLOT_W-1:0]            hitSlot;
    logic                         hitReady;
    logic [NUM_SLOTS-1:0]         visible;
    logic [NUM_SLOTS*LEVEL_W-1:0] slotLevel;
    logic                         spawnValid;
    logic [SLOT_W-1:0]            spawnSlot;
    logic                         spawnDir;
    logic [SLOT_W-1:0]            spawnParent;
    logic                         spawnDropped;
    logic                         allCleared;

    modport master (
        output startLevel, initLevel, hitValid, hitSlot,
        input  hitReady, visible, slotLevel, spawnValid, spawnSlot, spawnDir,
               spawnParent, spawnDropped, allCleared
    );

    modport slave (
        input  startLevel, initLevel, hitValid, hitSlot,
        output hitReady, visible, slotLevel, spawnValid, spawnSlot, spawnDir,
               spawnParent, spawnDropped, allCleared
    );
endinterface

// File: rtl/ball_split_scheduler.sv
// Ball slot pool and split sequencer: pops hit balls and spawns two smaller children.
// Optional one-entry hit buffer enabled by defining BALL_HIT_QUEUE_EN.
module ball_split_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int LEVEL_W   = 2
) (
    input  logic              clk,
    input  logic              resetN,
    ball_split_scheduler_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, SPAWN_L, SPAWN_R} state_t;

    state_t                             state_q, state_d;
    logic [NUM_SLOTS-1:0]               visible_q, visible_d, visPrev_q;
    logic [NUM_SLOTS-1:0][LEVEL_W-1:0]  level_q, level_d;
    logic [SLOT_W-1:0]                  parent_q, parent_d;
    logic [LEVEL_W-1:0]                 plevel_q, plevel_d;
    logic                               spawnValid_q, spawnValid_d;
    logic                               spawnDropped_q, spawnDropped_d;
    logic [SLOT_W-1:0]                  spawnSlot_q, spawnSlot_d;
    logic                               spawnDir_q, spawnDir_d;
    logic                               allCleared_q;

    logic                               hitReady;
    logic                               procValid;
    logic [SLOT_W-1:0]                  procSlot;
    logic                               freeFound;
    logic [SLOT_W-1:0]                  freeSlot;

`ifdef BALL_HIT_QUEUE_EN
    logic              hqValid_q, hqValid_d;
    logic [SLOT_W-1:0] hqSlot_q, hqSlot_d;

    assign hitReady  = !hqValid_q;
    // A buffered hit always wins in IDLE; a direct hit cannot coexist with it.
    assign procValid = (state_q == IDLE) && (hqValid_q || (bus.hitValid && hitReady));
    assign procSlot  = hqValid_q ? hqSlot_q : bus.hitSlot;

    always_comb begin
        hqValid_d = hqValid_q;
        hqSlot_d  = hqSlot_q;
        if (bus.startLevel) begin
            hqValid_d = 1'b0;
        end else if (state_q == IDLE) begin
            hqValid_d = 1'b0;
        end else if (bus.hitValid && hitReady) begin
            hqValid_d = 1'b1;
            hqSlot_d  = bus.hitSlot;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hqValid_q <= 1'b0;
            hqSlot_q  <= '0;
        end else begin
            hqValid_q <= hqValid_d;
            hqSlot_q  <= hqSlot_d;
        end
    end
`else
    assign hitReady  = (state_q == IDLE);
    assign procValid = bus.hitValid && hitReady;
    assign procSlot  = bus.hitSlot;
`endif

    // Lowest-index free slot; the slot taken by SPAWN_L is already visible here.
    always_comb begin
        freeFound = 1'b0;
        freeSlot  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!visible_q[i]) begin
                freeFound = 1'b1;
                freeSlot  = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        visible_d      = visible_q;
        level_d        = level_q;
        parent_d       = parent_q;
        plevel_d       = plevel_q;
        spawnValid_d   = 1'b0;
        spawnDropped_d = 1'b0;
        spawnSlot_d    = spawnSlot_q;
        spawnDir_d     = spawnDir_q;

        case (state_q)
            IDLE: begin
                if (procValid && visible_q[procSlot]) begin
                    visible_d[procSlot] = 1'b0;
                    parent_d            = procSlot;
                    plevel_d            = level_q[procSlot];
                    if (level_q[procSlot] != '0) state_d = SPAWN_L;
                end
            end
            SPAWN_L, SPAWN_R: begin
                if (freeFound) begin
                    visible_d[freeSlot] = 1'b1;
                    level_d[freeSlot]   = plevel_q - LEVEL_W'(1);
                    spawnValid_d        = 1'b1;
                    spawnSlot_d         = freeSlot;
                    spawnDir_d          = (state_q == SPAWN_R);
                end else begin
                    spawnDropped_d = 1'b1;
                end
                state_d = (state_q == SPAWN_L) ? SPAWN_R : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.startLevel) begin
            state_d        = IDLE;
            visible_d      = NUM_SLOTS'(1);
            level_d        = '0;
            level_d[0]     = bus.initLevel;
            spawnValid_d   = 1'b0;
            spawnDropped_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            visible_q      <= '0;
            visPrev_q      <= '0;
            level_q        <= '0;
            parent_q       <= '0;
            plevel_q       <= '0;
            spawnValid_q   <= 1'b0;
            spawnDropped_q <= 1'b0;
            spawnSlot_q    <= '0;
            spawnDir_q     <= 1'b0;
            allCleared_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            visible_q      <= visible_d;
            visPrev_q      <= visible_q;
            level_q        <= level_d;
            parent_q       <= parent_d;
            plevel_q       <= plevel_d;
            spawnValid_q   <= spawnValid_d;
            spawnDropped_q <= spawnDropped_d;
            spawnSlot_q    <= spawnSlot_d;
            spawnDir_q     <= spawnDir_d;
            allCleared_q   <= !bus.startLevel && (visPrev_q != '0) && (visible_q == '0);
        end
    end

    assign bus.hitReady     = hitReady;
    assign bus.visible      = visible_q;
    assign bus.slotLevel    = level_q;
    assign bus.spawnValid   = spawnValid_q;
    assign bus.spawnSlot    = spawnSlot_q;
    assign bus.spawnDir     = spawnDir_q;
    assign bus.spawnParent  = parent_q;
    assign bus.spawnDropped = spawnDropped_q;
    assign bus.allCleared   = allCleared_q;
endmodule

// File: tb/tb_ball_split_scheduler.sv
// Directed bench for ball_split_scheduler (8 slots, 3-bit levels so a 7-ball pool
// can still hold level-1 balls).
module tb_ball_split_scheduler;
    localparam int NS = 8;
    localparam int LW = 3;
`ifdef BALL_HIT_QUEUE_EN
    localparam bit QMODE = 1'b1;
`else
    localparam bit QMODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ball_split_scheduler_if #(.NUM_SLOTS(NS), .LEVEL_W(LW)) bus ();

    ball_split_scheduler #(.NUM_SLOTS(NS), .LEVEL_W(LW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lvl(input int i);
        return 32'(bus.slotLevel[i*LW +: LW]);
    endfunction

    task automatic start(input int lv);
        bus.startLevel = 1'b1;
        bus.initLevel  = LW'(lv);
        step();
        bus.startLevel = 1'b0;
    endtask

    // One-cycle hit, then run through both spawn cycles (ends at T+3).
    task automatic hit(input int s);
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'(s);
        step();
        bus.hitValid = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetN         = 1'b0;
        bus.startLevel = 1'b0;
        bus.initLevel  = '0;
        bus.hitValid   = 1'b0;
        bus.hitSlot    = '0;
        #12;
        chk("rst_visible", bus.visible, 8'h00);
        chk("rst_levels", bus.slotLevel, 24'h0);
        chk("rst_hitReady", bus.hitReady, 1);
        chk("rst_spawn", {bus.spawnValid, bus.spawnDropped, bus.spawnDir, bus.spawnSlot, bus.spawnParent}, 0);
        chk("rst_allCleared", bus.allCleared, 0);
        @(negedge clk);
        resetN = 1'b1;
        step();

        // Start level 2, then split slot 0
        start(2);
        chk("start_visible", bus.visible, 8'h01);
        chk("start_lvl0", lvl(0), 2);
        chk("start_allCleared", bus.allCleared, 0);
        step();
        chk("start_allCleared2", bus.allCleared, 0);

        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd0;
        chk("hit_ready_idle", bus.hitReady, 1);
        step();                                   // T+1
        bus.hitValid = 1'b0;
        chk("t1_visible", bus.visible, 8'h00);
        chk("t1_spawnValid", bus.spawnValid, 0);
        chk("t1_hitReady", bus.hitReady, QMODE ? 1 : 0);
        step();                                   // T+2
        chk("t2_spawnValid", bus.spawnValid, 1);
        chk("t2_spawn", {bus.spawnSlot, bus.spawnDir, bus.spawnParent}, {3'd0, 1'b0, 3'd0});
        chk("t2_visible", bus.visible, 8'h01);
        chk("t2_lvl0", lvl(0), 1);
        chk("t2_allCleared", bus.allCleared, 1);
        chk("t2_hitReady", bus.hitReady, QMODE ? 1 : 0);
        step();                                   // T+3
        chk("t3_spawnValid", bus.spawnValid, 1);
        chk("t3_spawn", {bus.spawnSlot, bus.spawnDir, bus.spawnParent}, {3'd1, 1'b1, 3'd0});
        chk("t3_visible", bus.visible, 8'h03);
        chk("t3_lvl1", lvl(1), 1);
        chk("t3_hitReady", bus.hitReady, 1);
        chk("t3_allCleared", bus.allCleared, 0);

        // Level-0 balls: back-to-back hits, last one clears the pool
        start(1);
        chk("s1_levels", bus.slotLevel, 24'h000001);
        hit(0);
        chk("l0_setup_visible", bus.visible, 8'h03);
        chk("l0_setup_levels", bus.slotLevel, 24'h0);
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd0;
        step();
        chk("b2b_visible1", bus.visible, 8'h02);
        chk("b2b_ready1", bus.hitReady, 1);
        bus.hitSlot = 3'd1;
        step();
        bus.hitValid = 1'b0;
        chk("b2b_visible2", bus.visible, 8'h00);
        chk("b2b_nospawn", {bus.spawnValid, bus.spawnDropped}, 0);
        chk("b2b_allCleared_early", bus.allCleared, 0);
        step();
        chk("b2b_allCleared", bus.allCleared, 1);
        chk("b2b_nospawn2", {bus.spawnValid, bus.spawnDropped}, 0);
        step();
        chk("b2b_allCleared_off", bus.allCleared, 0);

        // Invisible-slot hit is ignored
        start(4);
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd5;
        step();
        bus.hitValid = 1'b0;
        chk("inv_visible", bus.visible, 8'h01);
        chk("inv_ready", bus.hitReady, 1);
        step();
        chk("inv_pulses", {bus.spawnValid, bus.spawnDropped, bus.allCleared}, 0);
        chk("inv_visible2", bus.visible, 8'h01);

        // Build a 7-ball pool: six level-1 balls and one level-2 (slot 3)
        hit(0); hit(0); hit(1); hit(0); hit(1); hit(2);
        chk("pool7_visible", bus.visible, 8'h7F);
        chk("pool7_levels", bus.slotLevel, 24'o0_1_1_1_2_1_1_1);

        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd0;
        step();
        bus.hitValid = 1'b0;
        chk("reuse_t1_visible", bus.visible, 8'h7E);
        step();
        chk("reuse_left", {bus.spawnValid, bus.spawnSlot, bus.spawnDir, bus.spawnParent}, {1'b1, 3'd0, 1'b0, 3'd0});
        chk("reuse_left_lvl", lvl(0), 0);
        step();
        chk("reuse_right", {bus.spawnValid, bus.spawnSlot, bus.spawnDir}, {1'b1, 3'd7, 1'b1});
        chk("reuse_full", bus.visible, 8'hFF);
        chk("reuse_right_lvl", lvl(7), 0);

        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd1;
        step();
        bus.hitValid = 1'b0;
        chk("drop_t1_visible", bus.visible, 8'hFD);
        step();
        chk("drop_left", {bus.spawnValid, bus.spawnSlot, bus.spawnParent, bus.spawnDropped}, {1'b1, 3'd1, 3'd1, 1'b0});
        step();
        chk("drop_right", {bus.spawnValid, bus.spawnDropped}, 2'b01);
        chk("drop_visible", bus.visible, 8'hFF);
        chk("drop_ready", bus.hitReady, 1);
        step();
        chk("drop_pulse_off", bus.spawnDropped, 0);

        // startLevel during SPAWN_L aborts the split
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd3;
        step();
        bus.hitValid = 1'b0;
        chk("abort_t1_visible", bus.visible, 8'hF7);
        start(2);
        chk("abort_visible", bus.visible, 8'h01);
        chk("abort_levels", bus.slotLevel, 24'h000002);
        chk("abort_nospawn", {bus.spawnValid, bus.spawnDropped}, 0);
        step();
        chk("abort_nospawn_r", {bus.spawnValid, bus.spawnDropped, bus.allCleared}, 0);
        chk("abort_visible2", bus.visible, 8'h01);
        chk("abort_ready", bus.hitReady, 1);

`ifdef BALL_HIT_QUEUE_EN
        // Hit held during SPAWN_R is buffered and processed at T+3
        start(1);
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd0;
        step();
        bus.hitValid = 1'b0;
        step();                                   // T+2: SPAWN_R
        chk("q_ready_spawnR", bus.hitReady, 1);
        bus.hitValid = 1'b1;
        bus.hitSlot  = 3'd0;
        step();                                   // T+3: buffered
        bus.hitValid = 1'b0;
        chk("q_t3_visible", bus.visible, 8'h03);
        chk("q_t3_ready", bus.hitReady, 0);
        step();
        chk("q_t4_visible", bus.visible, 8'h02);
        chk("q_t4_ready", bus.hitReady, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ball_split_scheduler.md
# ball_split_scheduler

Slot manager and split sequencer for the bouncing-ball objects. It owns a pool of ball slots and drives each ball bitmap instance's `visible` input. On a hit it pops the struck ball and, unless the ball is already at the smallest size, spawns two balls one size smaller into free slots, announcing each spawn so the ball movement blocks can load position and direction. It sits between the collision logic and the per-slot ball movement/bitmap instances.

## Interface
- `NUM_SLOTS`, 8 — number of ball slots; power of two, 2..16.
- `LEVEL_W`, 2 — width of the size level; level 0 is the smallest ball and is not split.
- `clk` in 1 — system clock.
- `resetN` in 1 — asynchronous, active-low reset.
- `startLevel` in 1 — one-cycle pulse; clears the pool and loads slot 0 with `initLevel`.
- `initLevel` in LEVEL_W — size of the initial ball.
- `hitValid` in 1 — collision logic reports a hit.
- `hitSlot` in $clog2(NUM_SLOTS) — slot that was hit.
- `hitReady` out 1 — scheduler can accept a hit this cycle.
- `visible` out NUM_SLOTS — per-slot visible bit, wired to the bitmap `visible` inputs.
- `slotLevel` out NUM_SLOTS*LEVEL_W — packed per-slot level; slot i occupies bits [i*LEVEL_W +: LEVEL_W].
- `spawnValid` out 1 — one-cycle pulse: a ball was placed in `spawnSlot`.
- `spawnSlot` out $clog2(NUM_SLOTS) — slot index of the new ball.
- `spawnDir` out 1 — 0 = new ball moves left, 1 = new ball moves right.
- `spawnParent` out $clog2(NUM_SLOTS) — popped slot; the movement block copies the spawn position from this slot.
- `spawnDropped` out 1 — one-cycle pulse: a split child was discarded because no slot was free.
- `allCleared` out 1 — one-cycle pulse when `visible` goes from nonzero to all-zero.

## Operation
- States: IDLE, SPAWN_L, SPAWN_R.
- `hitReady` = 1 only in IDLE (also see Configuration).
- A hit is accepted when `hitValid && hitReady`.
  - If `visible[hitSlot]` = 0, the hit is ignored with no state change.
  - Otherwise `visible[hitSlot]` clears and the parent index and level are latched.
  - If the latched level = 0: stay in IDLE.
  - Else: go to SPAWN_L.
- SPAWN_L: pick the lowest-index slot with `visible` = 0. The just-freed parent slot is eligible.
  - Set its `visible` and set its level to parent level − 1.
  - Pulse `spawnValid` with `spawnDir` = 0.
  - Go to SPAWN_R.
- SPAWN_R: same as SPAWN_L with `spawnDir` = 1. The slot taken in SPAWN_L is excluded. Go to IDLE.
- No free slot in a SPAWN state: pulse `spawnDropped` instead of `spawnValid`, then advance as normal.
- `startLevel` has priority over everything in every state:
  - `visible` = 0 except bit 0 = 1; all levels = 0 except slot 0 = `initLevel`.
  - State returns to IDLE and any pending spawn or queued hit is discarded.
  - No `spawnValid` pulse and no `allCleared` pulse.
- `allCleared` compares registered `visible` with its value one cycle earlier.
- Levels of invisible slots retain stale values; consumers qualify them with `visible`.

## Timing
- Reset values: `visible` = 0, all levels = 0, state = IDLE, `hitReady` = 1. `spawnValid`, `spawnDropped`, `spawnSlot`, `spawnDir`, `spawnParent` and `allCleared` = 0.
- Hit accepted in cycle T:
  - `visible[hitSlot]` = 0 from T+1.
  - Left child is visible and `spawnValid` is high in T+2.
  - Right child in T+3.
  - `hitReady` high again in T+3.
- Level-0 hit accepted in T: `hitReady` stays high, so back-to-back hits are accepted every cycle.
- `allCleared` is high one cycle after `visible` first reads all-zero.
- All outputs are registered. There are no combinational paths from input to output, except `hitReady`, which is decoded from state only.

## Configuration
- `BALL_HIT_QUEUE_EN` defined:
  - Adds a one-entry hit buffer. `hitReady` = 1 whenever the buffer is empty, including in the SPAWN states.
  - A buffered hit is processed on the first cycle in IDLE, with the same rules as a direct hit (including the ignore-if-invisible check at processing time).
  - `startLevel` flushes the buffer.
- `BALL_HIT_QUEUE_EN` undefined: no buffer; `hitReady` = 1 only in IDLE, as above.

## Test plan
- Reset, then `startLevel` with `initLevel` = 2 → `visible` = 8'h01, slot 0 level 2, no `allCleared`.
- Hit slot 0 (level 2) at T:
  - T+1: `visible` = 0.
  - T+2: `spawnValid`, slot 0, dir 0, parent 0, level 1.
  - T+3: `spawnValid`, slot 1, dir 1, level 1; `visible` = 8'h03.
- Hit slot 1, level 0, in the last visible ball (`visible` = 8'h02) → `visible` = 0 next cycle, `allCleared` one cycle later, no spawn.
- Hit on an invisible slot 5 → no change, no pulses.
- Pool with 7 of 8 slots visible, hit a level-1 ball → the parent slot is reused for the left child, the right child gets the one free slot. Then a further level-1 hit with all 8 visible → left child reuses the parent slot, right child `spawnDropped`.
- `startLevel` asserted in SPAWN_L → pool reloaded, no SPAWN_R pulse. With `BALL_HIT_QUEUE_EN`, a hit held during SPAWN_R is processed at T+3.
